// File: rtl/hilo_pkg.sv
// Shared opcodes, FSM encoding and helpers for the HI/LO multiply unit.
package hilo_pkg;

  localparam logic [5:0] OP_MADD  = 6'd2;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_MSUB  = 6'd8;
  localparam logic [5:0] OP_MFHI  = 6'd15;
  localparam logic [5:0] OP_MTHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd17;
  localparam logic [5:0] OP_MTLO  = 6'd18;
  localparam logic [5:0] OP_MULT  = 6'd19;
  localparam logic [5:0] OP_MULTU = 6'd20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MADD) || (op == OP_MUL) ||
           (op == OP_MSUB) || (op == OP_MULT) ||
           (op == OP_MULTU);
  endfunction

  function automatic logic is_hilo_op(input logic [5:0] op);
    return is_mul_op(op) ||
           (op == OP_MFHI) || (op == OP_MTHI) ||
           (op == OP_MFLO) || (op == OP_MTLO);
  endfunction

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_mul_unit_step.sv
// One shift-add iteration: conditional add of the shifted multiplicand.
module shift_add_step (
  input  logic [63:0] p,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  input  logic [5:0]  step,
  output logic [63:0] p_nxt,
  output logic [31:0] mplier_nxt
);

  logic [63:0] addend;

  assign addend     = {32'd0, mcand} << step;
  assign p_nxt      = mplier[0] ? (p + addend) : p;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/hilo_mul_unit.sv
// Iterative multiply / HI-LO unit for the EX stage.
// Build option: HILO_EARLY_EXIT_EN ends MUL once the multiplier runs out.
module hilo_mul_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [5:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t      state, state_nxt;
  logic [31:0] hi_q, lo_q;
  logic [63:0] p_q, p_nxt;
  logic [31:0] mcand_q, mplier_q, mplier_nxt;
  logic [5:0]  step_q;
  logic        sign_q;
  logic [5:0]  op_q;
  logic        last_step;
  logic        sgn_op;
  logic [63:0] q, hilo, acc_add, acc_sub;

  shift_add_step u_step (
    .p         (p_q),
    .mcand     (mcand_q),
    .mplier    (mplier_q),
    .step      (step_q),
    .p_nxt     (p_nxt),
    .mplier_nxt(mplier_nxt)
  );

`ifdef HILO_EARLY_EXIT_EN
  assign last_step = (step_q == 6'd31) || (mplier_nxt == 32'd0);
`else
  assign last_step = (step_q == 6'd31);
`endif

  assign sgn_op  = (ALUOp != OP_MULTU);
  assign q       = sign_q ? -p_q : p_q;
  assign hilo    = {hi_q, lo_q};
  assign acc_add = hilo + q;
  assign acc_sub = hilo - q;

  assign Busy  = (state != IDLE);
  assign Done  = (state == FIN);
  assign Stall = Busy && Start && is_hilo_op(ALUOp);
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Result    = '0;
    unique case (state)
      IDLE: begin
        if (Start && is_mul_op(ALUOp)) state_nxt = MUL;
        if (Start && ALUOp == OP_MFHI) Result = hi_q;
        if (Start && ALUOp == OP_MFLO) Result = lo_q;
      end
      MUL: if (last_step) state_nxt = FIN;
      FIN: begin
        state_nxt = IDLE;
        if (op_q == OP_MUL) Result = q[31:0];
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      p_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      sign_q   <= 1'b0;
      op_q     <= '0;
    end else begin
      unique case (state)
        IDLE: if (Start) begin
          if (ALUOp == OP_MTHI) hi_q <= A;
          if (ALUOp == OP_MTLO) lo_q <= A;
          if (is_mul_op(ALUOp)) begin
            mcand_q  <= mag(A, sgn_op);
            mplier_q <= mag(B, sgn_op);
            sign_q   <= sgn_op && (A[31] ^ B[31]);
            op_q     <= ALUOp;
            p_q      <= '0;
            step_q   <= '0;
          end
        end
        MUL: begin
          p_q      <= p_nxt;
          mplier_q <= mplier_nxt;
          step_q   <= step_q + 6'd1;
        end
        FIN: begin
          // mul writes only Result; HI/LO stay architectural
          if (op_q == OP_MULT || op_q == OP_MULTU)
            {hi_q, lo_q} <= q;
          else if (op_q == OP_MADD)
            {hi_q, lo_q} <= acc_add;
          else if (op_q == OP_MSUB)
            {hi_q, lo_q} <= acc_sub;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hilo_mul_unit.md
# hilo_mul_unit

Multi-cycle multiply/HI-LO unit in the EX stage of the MIPS pipeline, downstream of the decode controller. It consumes the controller's 6-bit ALUOp codes for mult, multu, madd, msub and mul, and for the HI/LO move instructions mfhi, mthi, mflo and mtlo. Multiplies run on an iterative 32-step shift-add datapath. The unit raises Stall to hold the pipeline while an operation is in flight.

## Interface
- Parameters:
- WIDTH, 32: operand and register width. Only 32 is supported.
- Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  the EX-stage instruction is valid this cycle.
- ALUOp  in  6  controller opcode: 2 madd, 5 mul, 8 msub, 15 mfhi, 16 mthi, 17 mflo, 18 mtlo, 19 mult, 20 multu. Any other code is ignored.
- A  in  32  rs operand.
- B  in  32  rt operand.
- Busy  out  1  a multiply is in progress.
- Stall  out  1  Start carries a HI/LO-class op while Busy is high; holds EX in place.
- Done  out  1  one-cycle pulse on the final multiply cycle.
- Result  out  32  data for register write-back: mfhi gives HI, mflo gives LO, mul gives the low product word.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

## Operation
- States: IDLE, MUL, FIN.
- IDLE:
  - Start with mthi: HI <= A at the next edge.
  - Start with mtlo: LO <= A at the next edge.
  - Start with mfhi / mflo: Result = HI / LO combinationally, same cycle. No state change.
  - Start with 2, 5, 8, 19 or 20: latch operands, go to MUL.
    - Signed ops (all except multu): latch |A| and |B|; record sign = A[31]^B[31].
    - multu: latch A and B unsigned; sign = 0.
    - Latch the op code.
    - Clear the 64-bit product accumulator P and the 6-bit step counter.
- MUL, once per cycle:
  - If multiplier bit 0 is 1: P += multiplicand << step.
  - Shift the multiplier right by 1; increment the step counter.
  - After step 31 completes, go to FIN.
- FIN: Q = sign ? -P : P (64-bit two's complement). Done = 1. At the FIN edge:
  - mult / multu: {HI,LO} <= Q.
  - madd: {HI,LO} <= {HI,LO} + Q, modulo 2^64.
  - msub: {HI,LO} <= {HI,LO} - Q, modulo 2^64.
  - mul: Result = Q[31:0] while Done is high; HI and LO are unchanged.
  - Next state: IDLE.
- While Busy:
  - Start is not accepted.
  - Stall = Start & (ALUOp is one of the nine codes above).
  - Result shows the latched mul value only in FIN; otherwise it is 0.
- Reset value of every output: Busy 0, Stall 0, Done 0, Result 0, HI 0, LO 0. State resets to IDLE.

## Timing
- Multiply latency: Start at the cycle-0 edge; MUL occupies cycles 1–32; FIN is cycle 33 (Done high); HI/LO hold the new value from cycle 34.
- Busy is high in MUL and FIN. It drops in the cycle after FIN, so a back-to-back Start is accepted in cycle 34.
- Move ops: mthi/mtlo take effect one edge after Start; mfhi/mflo have zero latency.
- A Start in the same cycle the FSM is in FIN is stalled. The instruction retries in the next cycle and sees the updated HI/LO.
- Rst mid-operation: abandon the multiply, go to IDLE, clear HI/LO, Done is not asserted.
- Boundary, both operands 0x80000000 signed: magnitude 2^31, product 2^62, HI=0x40000000, LO=0.

## Configuration
- HILO_EARLY_EXIT_EN:
  - Defined: in MUL, when the remaining shifted multiplier is zero, go straight to FIN after the current step. Minimum of 1 MUL cycle, maximum of 32.
  - Undefined: always exactly 32 MUL cycles.
  - Results are identical in both builds; only latency differs.

## Structure
- Shared package `hilo_pkg`:
  - ALUOp localparams: OP_MADD=2, OP_MUL=5, OP_MSUB=8, OP_MFHI=15, OP_MTHI=16, OP_MFLO=17, OP_MTLO=18, OP_MULT=19, OP_MULTU=20.
  - State encoding: IDLE=2'd0, MUL=2'd1, FIN=2'd2.
  - Function `is_hilo_op(op)`.
- One sub-module, `shift_add_step`: combinational single-step P/multiplier update, instantiated once.

## Test plan
- mult A=-3 (0xFFFFFFFD), B=7 → Done at cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- mthi 5, mtlo 10, then madd A=2, B=3 → HI=5, LO=16. Then msub A=4, B=4 → HI=5, LO=0.
- mul A=6, B=-2 with HI=1, LO=2 → Result=0xFFFFFFF4 while Done is high; HI=1, LO=2 unchanged.
- mflo issued in cycle 5 of a mult → Stall high until cycle 34, then Result = new LO. Rst at cycle 10 of a mult → HI=LO=0, Busy=0 at the next cycle, Done never asserted.
- HILO_EARLY_EXIT_EN defined, mult A=5, B=3 → Done at cycle 3 (2 MUL cycles + FIN), LO=15.
